// File: rtl/duty_meter_pkg.sv
// Shared types and defaults for the duty-cycle meter.
package duty_meter_pkg;
  localparam int CNT_W_DEF   = 8;
  localparam int TIMEOUT_DEF = 200;
  localparam int ST_W        = 2;

  typedef enum logic [ST_W-1:0] {IDLE, ARMED, MEAS, STUCK} state_e;
endpackage

// File: rtl/duty_meter_edge_detect.sv
// Input conditioning and rising-edge detect for duty_meter.
// DUTY_METER_SYNC_EN adds a two-flop synchroniser ahead of s.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic s_o,
  output logic rise_o
);
  logic s_src;
  logic s_q, s_d_q;

`ifdef DUTY_METER_SYNC_EN
  logic meta_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) meta_q <= 1'b0;
    else     meta_q <= sig_i;
  end
  assign s_src = meta_q;
`else
  assign s_src = sig_i;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q   <= 1'b0;
      s_d_q <= 1'b0;
    end else begin
      s_q   <= s_src;
      s_d_q <= s_q;
    end
  end

  assign s_o    = s_q;
  assign rise_o = s_q & ~s_d_q;
endmodule

// File: rtl/duty_meter.sv
// Measures high time and period of sig_in between rising edges; flags a stuck input.
// Build option DUTY_METER_SYNC_EN selects the synchronised input path in edge_detect.
module duty_meter
  import duty_meter_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             stuck,
  output logic             stuck_level
);
  localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic s, rise;
  state_e state_q, state_d;
  logic [CNT_W-1:0] p_cnt_q, p_cnt_d, h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] high_q, high_d, per_q, per_d;
  logic mv_q, mv_d, stuck_q, stuck_d, lvl_q, lvl_d;
  logic p_sat, h_sat;

  edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (sig_in),
    .s_o    (s),
    .rise_o (rise)
  );

  assign p_sat = (p_cnt_q == TO);
  assign h_sat = (h_cnt_q == TO);

  always_comb begin
    state_d = state_q;
    high_d  = high_q;
    per_d   = per_q;
    mv_d    = 1'b0;
    stuck_d = stuck_q;
    lvl_d   = lvl_q;
    if (rise) begin
      p_cnt_d = ONE;
      h_cnt_d = ONE;
    end else begin
      p_cnt_d = p_sat ? p_cnt_q : p_cnt_q + ONE;
      h_cnt_d = h_sat ? h_cnt_q : h_cnt_q + CNT_W'(s);
    end
    // p_cnt doubles as the idle timer, so every non-STUCK state times out the same way
    case (state_q)
      IDLE: begin
        if (rise) state_d = ARMED;
        else if (p_sat) begin
          state_d = STUCK;
          stuck_d = 1'b1;
          lvl_d   = s;
        end
      end
      ARMED, MEAS: begin
        // a rise here closes a full period that began on a counted rise
        if (rise) begin
          state_d = MEAS;
          high_d  = h_cnt_q;
          per_d   = p_cnt_q;
          mv_d    = 1'b1;
        end else if (p_sat) begin
          state_d = STUCK;
          stuck_d = 1'b1;
          lvl_d   = s;
        end
      end
      STUCK: begin
        if (rise) begin
          state_d = ARMED;
          stuck_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      p_cnt_q <= '0;
      h_cnt_q <= '0;
      high_q  <= '0;
      per_q   <= '0;
      mv_q    <= 1'b0;
      stuck_q <= 1'b0;
      lvl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_cnt_q <= p_cnt_d;
      h_cnt_q <= h_cnt_d;
      high_q  <= high_d;
      per_q   <= per_d;
      mv_q    <= mv_d;
      stuck_q <= stuck_d;
      lvl_q   <= lvl_d;
    end
  end

  assign meas_valid  = mv_q;
  assign high_cnt    = high_q;
  assign period_cnt  = per_q;
  assign stuck       = stuck_q;
  assign stuck_level = lvl_q;
endmodule

// File: tb/tb_duty_meter.sv
// Self-checking bench for duty_meter: rise-to-rise reference model plus directed checks.
module tb_duty_meter;
  localparam int T = 200;
`ifdef DUTY_METER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int SD = LAT - 2;

  logic clk = 1'b0, rst = 1'b0, sig_in = 1'b0;
  logic meas_valid, stuck, stuck_level;
  logic [7:0] high_cnt, period_cnt;

  always #5 clk = ~clk;

  duty_meter #(.CNT_W(8), .TIMEOUT(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .meas_valid (meas_valid),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .stuck      (stuck),
    .stuck_level(stuck_level)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: works on rise times and cycle gaps, not on counters.
  int  cyc = 0, last_rise = 0, hones = 0;
  bit  real_prev = 0, m_s = 0, m_sold = 0, m_sync = 0;
  logic       e_mv = 0, e_stuck = 0, e_lvl = 0;
  logic [7:0] e_hi = 0, e_per = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      cyc = 0; last_rise = 0; hones = 0; real_prev = 0;
      m_s = 0; m_sold = 0; m_sync = 0;
      e_mv = 0; e_stuck = 0; e_lvl = 0; e_hi = 0; e_per = 0;
    end else begin
      int gap;
      gap  = cyc - last_rise;
      e_mv = 0;
      if (m_s && !m_sold) begin
        if (real_prev && gap <= T) begin
          e_mv = 1; e_hi = 8'(hones); e_per = 8'(gap);
        end
        e_stuck = 0; last_rise = cyc; real_prev = 1; hones = 1;
      end else begin
        if (gap == T) begin e_stuck = 1; e_lvl = m_s; end
        hones += int'(m_s);
      end
      cyc++;
      m_sold = m_s;
`ifdef DUTY_METER_SYNC_EN
      m_s = m_sync; m_sync = sig_in;
`else
      m_s = sig_in;
`endif
    end
  end

  // Per-cycle compare against the model, plus directed value/spacing checks.
  int tb_cyc = 0, last_mv = -1, mv_cnt = 0, exp_hi = -1, exp_per = -1;

  initial forever begin
    @(negedge clk);
    tb_cyc++;
    chk("valid",  32'(meas_valid),  32'(e_mv));
    chk("stuck",  32'(stuck),       32'(e_stuck));
    chk("level",  32'(stuck_level), 32'(e_lvl));
    chk("high",   32'(high_cnt),    32'(e_hi));
    chk("period", 32'(period_cnt),  32'(e_per));
    if (meas_valid === 1'b1) begin
      mv_cnt++;
      if (exp_per >= 0) begin
        chk("dir_high",   32'(high_cnt),   exp_hi);
        chk("dir_period", 32'(period_cnt), exp_per);
        if (last_mv >= 0) chk("dir_gap", tb_cyc - last_mv, exp_per);
      end
      last_mv = tb_cyc;
    end
  end

  task automatic tick(input logic v);
    sig_in = v;
    @(posedge clk);
    #2;
  endtask

  task automatic no_exp();
    exp_hi = -1; exp_per = -1;
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      if (r == 0) no_exp();
      if (r == 2) begin exp_hi = hi; exp_per = hi + lo; last_mv = -1; end
      for (int c = 0; c < hi + lo; c++) tick(c < hi);
    end
  endtask

  initial begin
    int snap, lat, first_i;
    logic v;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid",  32'(meas_valid),  0);
    chk("rst_high",   32'(high_cnt),    0);
    chk("rst_period", 32'(period_cnt),  0);
    chk("rst_stuck",  32'(stuck),       0);
    chk("rst_level",  32'(stuck_level), 0);
    rst = 1'b0;
    repeat (20) tick(1'b0);
    chk("idle_no_strobe", mv_cnt, 0);

    // 20% generator: count 0..9, high when count >= 8
    snap = mv_cnt;
    for (int r = 0; r < 8; r++) begin
      if (r == 2) begin exp_hi = 2; exp_per = 10; last_mv = -1; end
      for (int c = 0; c < 10; c++) tick(c >= 8);
    end
    repeat (8) tick(1'b0);
    chk("pct20_strobes", mv_cnt - snap, 7);

    // period change: the first new-rate strobe reports the old 3/8 period
    wave(3, 5, 4);
    wave(1, 3, 5);
    wave(3, 5, 4);

    // latency from the edge that first samples the input high
    no_exp();
    lat = 0;
    sig_in = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (meas_valid === 1'b1 && lat == 0) lat = k;
      #1;
    end
    chk("latency", lat, LAT);
    repeat (5) tick(1'b0);

    // stuck low after lock
    wave(3, 5, 4);
    no_exp();
    first_i = -1;
    for (int i = 0; i < T + 10; i++) begin
      tick(1'b0);
      if (stuck === 1'b1 && first_i < 0) first_i = i;
    end
    chk("stuck_lo_time",  first_i, T - 7 + SD);
    chk("stuck_lo",       32'(stuck),       1);
    chk("stuck_lo_level", 32'(stuck_level), 0);
    chk("stuck_lo_high",  32'(high_cnt),    3);
    chk("stuck_lo_per",   32'(period_cnt),  8);
    wave(2, 3, 4);
    chk("recovered", 32'(stuck), 0);

    // stuck high holds the last published measurement
    no_exp();
    repeat (T + 10) tick(1'b1);
    chk("stuck_hi",       32'(stuck),       1);
    chk("stuck_hi_level", 32'(stuck_level), 1);
    chk("stuck_hi_high",  32'(high_cnt),    2);
    chk("stuck_hi_per",   32'(period_cnt),  5);
    repeat (3) tick(1'b0);

    // minimum period, then periods exactly at and just past the timeout
    wave(1, 1, 6);
    wave(1, T - 1, 3);
    chk("period_at_timeout", 32'(period_cnt), T);
    chk("no_stuck_at_timeout", 32'(stuck), 0);
    wave(1, T, 2);

    // async reset five cycles into a period
    wave(3, 5, 3);
    no_exp();
    repeat (3) tick(1'b1);
    repeat (2) tick(1'b0);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid",  32'(meas_valid),  0);
    chk("arst_high",   32'(high_cnt),    0);
    chk("arst_period", 32'(period_cnt),  0);
    chk("arst_stuck",  32'(stuck),       0);
    @(posedge clk);
    #2 rst = 1'b0;
    snap = mv_cnt;
    wave(3, 5, 4);
    chk("post_rst_strobes", mv_cnt - snap, 3);

    // randomized segments
    for (int k = 0; k < 10; k++) begin
      int kind;
      kind = int'($urandom_range(0, 7));
      case (kind)
        0: begin
          no_exp();
          v = ($urandom_range(0, 1) == 1);
          repeat (T + $urandom_range(1, 20)) tick(v);
        end
        1: begin
          no_exp();
          repeat ($urandom_range(0, 4)) tick(1'b1);
          #1 rst = 1'b1;
          @(posedge clk);
          #2 rst = 1'b0;
        end
        default: wave(int'($urandom_range(1, 6)), int'($urandom_range(1, 8)),
                      int'($urandom_range(3, 6)));
      endcase
    end
    repeat (4) tick(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
